// File: rtl/multicycle_ctrl_if.sv
// Memory request handshake between the multi-cycle control unit and the
// instruction/data memory.
//   mem_req   : request, held until mem_ready is seen high
//   mem_we    : store request, qualifies mem_req
//   addr_sel  : memory address source (0 = PC, 1 = ALU result)
//   mem_ready : memory completes the current request this cycle
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for an RV32I core. Sequences one instruction at a
// time through fetch, decode, execute, memory and writeback, drives the
// datapath select lines, owns the memory handshake, traps on unsupported
// opcodes and counts retired instructions.
//
// Ports:
//   CLK, RESET_N         clock, asynchronous active-low reset
//   mem                  memory handshake (master side)
//   instr_opcode         opcode field of the instruction register
//   take_branch          branch condition from the ALU comparator
//   ir_we, pc_we, reg_we datapath write strobes
//   pc_src, imm_sel, alu_a_sel, alu_b_sel, alu_op, wb_sel  datapath selects
//   illegal              sticky trap flag
//   retired              one-cycle pulse per completed instruction
//   retire_count         retired-instruction counter (wraps)
//   state                current state, for debug
//
// state  | meaning
// IDLE   | after reset, all outputs quiet
// FETCH  | instruction read from memory at PC
// DECODE | opcode class latched
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | load/store data access; stores retire here
// WB     | register writeback and PC update
// TRAP   | unsupported opcode, held until reset
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    multicycle_ctrl_if.master    mem,
    input  logic [6:0]           instr_opcode,
    input  logic                 take_branch,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic [2:0]           imm_sel,
    output logic [1:0]           alu_a_sel,
    output logic                 alu_b_sel,
    output logic [1:0]           alu_op,
    output logic                 reg_we,
    output logic [1:0]           wb_sel,
    output logic                 illegal,
    output logic                 retired,
    output logic [CNT_W-1:0]     retire_count,
    output logic [2:0]           state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [3:0] CLS_LOAD    = 4'd0;
    localparam logic [3:0] CLS_STORE   = 4'd1;
    localparam logic [3:0] CLS_BRANCH  = 4'd2;
    localparam logic [3:0] CLS_OPIMM   = 4'd3;
    localparam logic [3:0] CLS_OP      = 4'd4;
    localparam logic [3:0] CLS_LUI     = 4'd5;
    localparam logic [3:0] CLS_AUIPC   = 4'd6;
    localparam logic [3:0] CLS_JAL     = 4'd7;
    localparam logic [3:0] CLS_JALR    = 4'd8;
    localparam logic [3:0] CLS_ILLEGAL = 4'd15;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_FUNC = 2'd1;
    localparam logic [1:0] OP_CMP  = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    logic [2:0]       state_q, state_d;
    logic [3:0]       cls_q, cls_d;
    logic [CNT_W-1:0] retire_count_q, retire_count_d;
    logic [3:0]       cls_dec;
    logic [2:0]       imm_fmt;

    always_comb begin
        case (instr_opcode)
            7'b0000011: cls_dec = CLS_LOAD;
            7'b0100011: cls_dec = CLS_STORE;
            7'b1100011: cls_dec = CLS_BRANCH;
            7'b0010011: cls_dec = CLS_OPIMM;
            7'b0110011: cls_dec = CLS_OP;
            7'b0110111: cls_dec = CLS_LUI;
            7'b0010111: cls_dec = CLS_AUIPC;
            7'b1101111: cls_dec = CLS_JAL;
            7'b1100111: cls_dec = CLS_JALR;
            default:    cls_dec = CLS_ILLEGAL;
        endcase
    end

    always_comb begin
        case (cls_q)
            CLS_STORE:           imm_fmt = IMM_S;
            CLS_BRANCH:          imm_fmt = IMM_B;
            CLS_LUI, CLS_AUIPC:  imm_fmt = IMM_U;
            CLS_JAL:             imm_fmt = IMM_J;
            default:             imm_fmt = IMM_I;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_PLUS4;
        imm_sel      = IMM_I;
        alu_a_sel    = A_RS1;
        alu_b_sel    = 1'b0;
        alu_op       = OP_ADD;
        reg_we       = 1'b0;
        wb_sel       = WB_ALU;
        illegal      = 1'b0;
        retired      = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                cls_d   = cls_dec;
                state_d = (cls_dec == CLS_ILLEGAL) ? S_TRAP : S_EXEC;
            end

            S_EXEC: begin
                imm_sel = imm_fmt;
                case (cls_q)
                    CLS_OP: begin
                        alu_op = OP_FUNC;
                    end
                    CLS_OPIMM: begin
                        alu_b_sel = 1'b1;
                        alu_op    = OP_FUNC;
                    end
                    CLS_AUIPC, CLS_JAL: begin
                        alu_a_sel = A_PC;
                        alu_b_sel = 1'b1;
                    end
                    CLS_LUI: begin
                        alu_a_sel = A_ZERO;
                        alu_b_sel = 1'b1;
                    end
                    CLS_BRANCH: begin
                        alu_op = OP_CMP;
                    end
                    default: begin
                        alu_b_sel = 1'b1;
                    end
                endcase

                if (cls_q == CLS_BRANCH) begin
                    pc_we   = 1'b1;
                    pc_src  = take_branch ? PC_IMM : PC_PLUS4;
                    retired = 1'b1;
                    state_d = S_FETCH;
                end else if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                imm_sel      = imm_fmt;
                mem.mem_req  = 1'b1;
                mem.addr_sel = 1'b1;
                mem.mem_we   = (cls_q == CLS_STORE);
                if (mem.mem_ready) begin
                    if (cls_q == CLS_STORE) begin
                        pc_we   = 1'b1;
                        retired = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                imm_sel = imm_fmt;
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                retired = 1'b1;
                state_d = S_FETCH;
                case (cls_q)
                    CLS_LOAD: wb_sel = WB_MEM;
                    CLS_JAL: begin
                        wb_sel = WB_PC4;
                        pc_src = PC_IMM;
                    end
                    CLS_JALR: begin
                        wb_sel = WB_PC4;
                        pc_src = PC_ALU;
                    end
                    default: wb_sel = WB_ALU;
                endcase
            end

            S_TRAP: illegal = 1'b1;

            default: state_d = S_IDLE;
        endcase

        retire_count_d = retired ? retire_count_q + CNT_W'(1) : retire_count_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= S_IDLE;
            cls_q          <= CLS_ILLEGAL;
            retire_count_q <= '0;
        end else begin
            state_q        <= state_d;
            cls_q          <= cls_d;
            retire_count_q <= retire_count_d;
        end
    end

    assign state        = state_q;
    assign retire_count = retire_count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl. Each instruction is run
// from FETCH entry until its retire pulse; selected outputs are captured along
// the way and compared against hand-computed values.
module tb_multicycle_ctrl;

    logic        CLK;
    logic        RESET_N;
    logic [6:0]  instr_opcode;
    logic        take_branch;
    logic        ir_we, pc_we, reg_we, illegal, retired, alu_b_sel;
    logic [1:0]  pc_src, alu_a_sel, alu_op, wb_sel;
    logic [2:0]  imm_sel, state;
    logic [31:0] retire_count;

    multicycle_ctrl_if mif ();

    multicycle_ctrl #(.CNT_W(32)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .mem          (mif),
        .instr_opcode (instr_opcode),
        .take_branch  (take_branch),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .imm_sel      (imm_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .alu_op       (alu_op),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .illegal      (illegal),
        .retired      (retired),
        .retire_count (retire_count),
        .state        (state)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_errors = 0;
    int exp_count = 0;

    // captured per instruction
    int          r_lat;
    int          r_mem_cycles;
    bit          r_done, r_any_reg_we, r_overlap, r_mem_we_seen;
    logic [1:0]  r_wb_sel, r_pc_src, r_alu_a, r_alu_op;
    logic        r_reg_we, r_pc_we, r_alu_b;
    logic [2:0]  r_imm;
    logic [2:0]  r_trace [0:15];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with the DUT in FETCH; returns at the negedge after
    // the retire cycle.
    task automatic run_instr(input logic [6:0] op, input int f_wait, input int m_wait, input logic br);
        int fcnt = 0;
        int mcnt = 0;
        r_done = 0; r_lat = 0; r_mem_cycles = 0;
        r_any_reg_we = 0; r_overlap = 0; r_mem_we_seen = 0;
        r_wb_sel = '0; r_pc_src = '0; r_reg_we = 0; r_pc_we = 0;
        r_alu_a = '0; r_alu_op = '0; r_alu_b = 0; r_imm = '0;
        for (int i = 0; i < 16; i++) r_trace[i] = 3'd6;
        instr_opcode = op;
        take_branch  = br;
        for (int c = 0; c < 40 && !r_done; c++) begin
            mif.mem_ready = 1'b0;
            if (state == 3'd1) begin
                mif.mem_ready = (fcnt >= f_wait);
                fcnt++;
            end
            if (state == 3'd4) begin
                mif.mem_ready = (mcnt >= m_wait);
                mcnt++;
            end
            #1;
            if (c < 16) r_trace[c] = state;
            if (state == 3'd4) begin
                if (mif.mem_req && mif.addr_sel) r_mem_cycles++;
                if (mif.mem_we) r_mem_we_seen = 1;
            end
            if (state == 3'd3) begin
                r_imm    = imm_sel;
                r_alu_a  = alu_a_sel;
                r_alu_b  = alu_b_sel;
                r_alu_op = alu_op;
            end
            if (reg_we) r_any_reg_we = 1;
            if (ir_we && (pc_we || reg_we || retired)) r_overlap = 1;
            if (retired) begin
                r_done   = 1;
                r_lat    = c + 1;
                r_reg_we = reg_we;
                r_pc_we  = pc_we;
                r_wb_sel = wb_sel;
                r_pc_src = pc_src;
            end
            @(negedge CLK);
        end
        mif.mem_ready = 1'b0;
        if (r_done) exp_count++;
        check_eq("retire_seen", 32'(r_done), 32'd1);
        check_eq("back_to_fetch", 32'(state), 32'd1);
        check_eq("no_ir_overlap", 32'(r_overlap), 32'd0);
        check_eq("retire_count", retire_count, 32'(exp_count));
    endtask

    initial begin
        RESET_N       = 1'b0;
        instr_opcode  = 7'd0;
        take_branch   = 1'b0;
        mif.mem_ready = 1'b0;
        repeat (2) @(negedge CLK);
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_mem_req", 32'(mif.mem_req), 32'd0);
        check_eq("rst_count", retire_count, 32'd0);
        check_eq("rst_illegal", 32'(illegal), 32'd0);
        RESET_N = 1'b1;
        @(negedge CLK);
        check_eq("first_fetch", 32'(state), 32'd1);

        // ADDI, zero wait states
        run_instr(7'b0010011, 0, 0, 1'b0);
        check_eq("addi_tr0", 32'(r_trace[0]), 32'd1);
        check_eq("addi_tr1", 32'(r_trace[1]), 32'd2);
        check_eq("addi_tr2", 32'(r_trace[2]), 32'd3);
        check_eq("addi_tr3", 32'(r_trace[3]), 32'd5);
        check_eq("addi_lat", 32'(r_lat), 32'd4);
        check_eq("addi_reg_we", 32'(r_reg_we), 32'd1);
        check_eq("addi_wb_sel", 32'(r_wb_sel), 32'd0);
        check_eq("addi_pc_src", 32'(r_pc_src), 32'd0);
        check_eq("addi_alu_op", 32'(r_alu_op), 32'd1);
        check_eq("addi_alu_b", 32'(r_alu_b), 32'd1);

        // LOAD, three wait states in MEM
        run_instr(7'b0000011, 0, 3, 1'b0);
        check_eq("load_lat", 32'(r_lat), 32'd8);
        check_eq("load_mem_cycles", 32'(r_mem_cycles), 32'd4);
        check_eq("load_mem_we", 32'(r_mem_we_seen), 32'd0);
        check_eq("load_wb_sel", 32'(r_wb_sel), 32'd1);
        check_eq("load_imm", 32'(r_imm), 32'd0);

        // BRANCH taken / not taken
        run_instr(7'b1100011, 0, 0, 1'b1);
        check_eq("br_t_lat", 32'(r_lat), 32'd3);
        check_eq("br_t_pc_we", 32'(r_pc_we), 32'd1);
        check_eq("br_t_pc_src", 32'(r_pc_src), 32'd1);
        check_eq("br_t_reg_we", 32'(r_any_reg_we), 32'd0);
        check_eq("br_t_alu_op", 32'(r_alu_op), 32'd2);
        check_eq("br_t_imm", 32'(r_imm), 32'd2);
        run_instr(7'b1100011, 0, 0, 1'b0);
        check_eq("br_n_lat", 32'(r_lat), 32'd3);
        check_eq("br_n_pc_src", 32'(r_pc_src), 32'd0);
        check_eq("br_n_reg_we", 32'(r_any_reg_we), 32'd0);

        // STORE
        run_instr(7'b0100011, 0, 0, 1'b0);
        check_eq("st_lat", 32'(r_lat), 32'd4);
        check_eq("st_mem_we", 32'(r_mem_we_seen), 32'd1);
        check_eq("st_pc_we", 32'(r_pc_we), 32'd1);
        check_eq("st_reg_we", 32'(r_any_reg_we), 32'd0);
        check_eq("st_imm", 32'(r_imm), 32'd1);

        // JALR, JAL
        run_instr(7'b1100111, 0, 0, 1'b0);
        check_eq("jalr_imm", 32'(r_imm), 32'd0);
        check_eq("jalr_wb_sel", 32'(r_wb_sel), 32'd2);
        check_eq("jalr_pc_src", 32'(r_pc_src), 32'd2);
        run_instr(7'b1101111, 0, 0, 1'b0);
        check_eq("jal_imm", 32'(r_imm), 32'd4);
        check_eq("jal_pc_src", 32'(r_pc_src), 32'd1);
        check_eq("jal_alu_a", 32'(r_alu_a), 32'd1);
        check_eq("jal_lat", 32'(r_lat), 32'd4);

        // LUI, AUIPC, OP with two fetch wait states
        run_instr(7'b0110111, 0, 0, 1'b0);
        check_eq("lui_alu_a", 32'(r_alu_a), 32'd2);
        check_eq("lui_imm", 32'(r_imm), 32'd3);
        run_instr(7'b0010111, 0, 0, 1'b0);
        check_eq("auipc_alu_a", 32'(r_alu_a), 32'd1);
        check_eq("auipc_alu_op", 32'(r_alu_op), 32'd0);
        run_instr(7'b0110011, 2, 0, 1'b0);
        check_eq("op_lat", 32'(r_lat), 32'd6);
        check_eq("op_alu_b", 32'(r_alu_b), 32'd0);
        check_eq("op_alu_op", 32'(r_alu_op), 32'd1);

        // illegal opcode -> TRAP, held quiet
        instr_opcode  = 7'b1111111;
        mif.mem_ready = 1'b1;
        @(negedge CLK);
        check_eq("trap_decode", 32'(state), 32'd2);
        @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
            check_eq("trap_state", 32'(state), 32'd7);
            check_eq("trap_illegal", 32'(illegal), 32'd1);
            check_eq("trap_strobes",
                     32'({ir_we, pc_we, reg_we, retired, mif.mem_req, mif.mem_we}), 32'd0);
            @(negedge CLK);
        end
        check_eq("trap_count", retire_count, 32'(exp_count));
        mif.mem_ready = 1'b0;

        // reset during MEM of a STORE
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        check_eq("rst2_fetch", 32'(state), 32'd1);
        instr_opcode  = 7'b0100011;
        mif.mem_ready = 1'b1;
        @(negedge CLK);
        mif.mem_ready = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check_eq("st_in_mem", 32'(state), 32'd4);
        check_eq("st_mem_we_held", 32'(mif.mem_we), 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        check_eq("arst_state", 32'(state), 32'd0);
        check_eq("arst_mem_req", 32'(mif.mem_req), 32'd0);
        check_eq("arst_count", retire_count, 32'd0);
        check_eq("arst_pc_we", 32'(pc_we), 32'd0);
        @(negedge CLK);
        RESET_N   = 1'b1;
        exp_count = 0;
        @(negedge CLK);
        run_instr(7'b0010011, 0, 0, 1'b0);
        check_eq("post_rst_lat", 32'(r_lat), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
